// File: rtl/uart_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_pkg : shared UART definitions (bus map, frame format, FSM)    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package uart_tx_pkg;

    // Existing register-bus definitions for the UART block
    localparam int UART_ADDR_WIDTH   = 4;
    localparam int UART_BUS_WIDTH    = 32;
    localparam logic [UART_ADDR_WIDTH-1:0] UART_TX_DATA_ADDR = 4'h0;
    localparam logic [UART_ADDR_WIDTH-1:0] UART_STATUS_ADDR  = 4'h4;

    // 8N1 frame format; default divider is 100 MHz / 115200 baud
    localparam int UART_DATA_BITS        = 8;
    localparam int UART_STOP_BITS        = 1;
    localparam int UART_DEFAULT_DIV_RATE = 868;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_tx_state_e;

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx : 8N1 serial transmitter, registered outputs, inline baud gen |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DIV_RATE = UART_DEFAULT_DIV_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_end,
    output logic       tx
);

    localparam int c_CNT_W = $clog2(DIV_RATE);
    localparam logic [c_CNT_W-1:0] c_BAUD_MAX = c_CNT_W'(DIV_RATE - 1);
    localparam logic [c_CNT_W-1:0] c_BAUD_ONE = c_CNT_W'(1);
    localparam logic [2:0]         c_LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_e     r_state;
    logic [c_CNT_W-1:0] r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               r_busy;
    logic               r_end;
    logic               w_baud_done;

    assign w_baud_done = (r_baud == c_BAUD_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_end   <= 1'b0;
        end else begin
            r_end <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_start) begin
                        r_state <= ST_START;
                        r_shift <= tx_data;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_baud_done) begin
                        // LSB goes out first; shift right to expose the next bit
                        r_state <= ST_DATA;
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit == c_LAST_BIT) begin
                            r_state <= ST_STOP;
                            r_bit   <= '0;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                ST_STOP: begin
                    if (w_baud_done) begin
                        r_state <= ST_IDLE;
                        r_baud  <= '0;
                        r_busy  <= 1'b0;
                        r_end   <= 1'b1;
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_end  = r_end;

endmodule : uart_tx
`default_nettype wire
